// File: rtl/move_sequencer_if.sv
// Move/spawn handshake between the sequencer and the 2048 datapath.
// The sequencer is the master; the datapath is the slave.
interface move_sequencer_if;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       move_done;
    logic       move_changed;
    logic       spawn_req;
    logic       spawn_done;

    modport master (
        output move_valid, move_dir, spawn_req,
        input  move_ready, move_done, move_changed, spawn_done
    );

    modport slave (
        input  move_valid, move_dir, spawn_req,
        output move_ready, move_done, move_changed, spawn_done
    );
endinterface

// File: rtl/move_sequencer.sv
// Button debounce, move queue and move/spawn/commit sequencing
// for the 2048 game datapath; owns the welcome-screen state.
module move_sequencer #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int QUEUE_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              btn,
    input  logic                    frame_tick,
    move_sequencer_if.master        dp,
    output logic                    grid_commit,
    output logic                    show_welcome,
    output logic                    busy,
    output logic                    overflow,
    output logic                    timeout_err
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]    DF    = 3'(DEBOUNCE_FRAMES);
    localparam logic [AW:0]   QD    = (AW + 1)'(QUEUE_DEPTH);
    localparam logic [TW-1:0] T_HIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WELCOME, IDLE, ISSUE, WAIT_MOVE, SPAWN, WAIT_FRAME
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    cand, stable, stable_q, press;
    logic [2:0]    cnt [4];
    logic          press_any;
    logic [1:0]    press_dir;
    logic [1:0]    mem [QUEUE_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, fill;
    logic          empty, full, pop, push_req, push, drop;
    logic [1:0]    head;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit, tmo_fire;
    logic          valid, spawn;

    // Per-button candidate/stability counters advanced on frame ticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand     <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            stable_q <= stable;
            if (frame_tick) begin
                for (int i = 0; i < 4; i++) begin
                    if (btn[i] == cand[i]) begin
                        if (cnt[i] != DF) cnt[i] <= cnt[i] + 3'd1;
                        if (cnt[i] >= DF - 3'd1) stable[i] <= cand[i];
                    end else begin
                        cand[i] <= btn[i];
                        cnt[i]  <= '0;
                    end
                end
            end
        end
    end

    assign press = stable & ~stable_q;

    // Pick one press per cycle: up > down > left > right
    always_comb begin
        press_any = |press;
        press_dir = 2'd0;
        if (press[0])      press_dir = 2'd0;
        else if (press[1]) press_dir = 2'd1;
        else if (press[2]) press_dir = 2'd2;
        else if (press[3]) press_dir = 2'd3;
    end

    assign fill     = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (fill == QD);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign pop      = valid && dp.move_ready;
    assign push_req = press_any && (state != WELCOME);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Move FIFO; a pop frees the slot for a same-cycle push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= press_dir;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == T_HIT);

    // State register, timeout counter and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= WELCOME;
            tmo_cnt     <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state &&
                (state_nx == WAIT_MOVE || state_nx == SPAWN))
                tmo_cnt <= '0;
            else if (state == WAIT_MOVE || state == SPAWN)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (drop)     overflow    <= 1'b1;
            if (tmo_fire) timeout_err <= 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx    = state;
        valid       = 1'b0;
        spawn       = 1'b0;
        grid_commit = 1'b0;
        tmo_fire    = 1'b0;
        unique case (state)
            WELCOME: if (press_any) state_nx = IDLE;
            IDLE:    if (!empty) state_nx = ISSUE;
            ISSUE: begin
                valid = 1'b1;
                if (dp.move_ready) state_nx = WAIT_MOVE;
            end
            WAIT_MOVE: begin
                if (dp.move_done) begin
                    state_nx = dp.move_changed ? SPAWN : IDLE;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_nx = IDLE;
                end
            end
            SPAWN: begin
                spawn = 1'b1;
                if (dp.spawn_done) begin
                    state_nx = WAIT_FRAME;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT_FRAME: begin
                if (frame_tick) begin
                    grid_commit = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = WELCOME;
        endcase
    end

    assign dp.move_valid = valid;
    assign dp.move_dir   = valid ? head : 2'd0;
    assign dp.spawn_req  = spawn;
    assign show_welcome  = (state == WELCOME);
    assign busy          = (state != IDLE) && (state != WELCOME);
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: welcome exit, move/spawn/commit,
// arbitration, queue overflow, no-change moves, timeout and reset.
module tb_move_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'd0;
    logic       frame_tick = 1'b0;
    logic       grid_commit, show_welcome, busy, overflow, timeout_err;

    move_sequencer_if dp ();

    move_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .frame_tick   (frame_tick),
        .dp           (dp),
        .grid_commit  (grid_commit),
        .show_welcome (show_welcome),
        .busy         (busy),
        .overflow     (overflow),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncommit = 0;
    int nspawn = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int issued[$];

    // Cycle counter
    always @(posedge clk) cyc++;

    // Mid-cycle monitor of commits, spawn cycles and accepted moves
    always @(negedge clk) begin
        if (grid_commit) ncommit++;
        if (dp.spawn_req) nspawn++;
        if (dp.move_valid && dp.move_ready) begin
            issued.push_back(int'(dp.move_dir));
            hs_cyc = cyc;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
    endtask

    task automatic press(input logic [3:0] v);
        btn = v;
        repeat (3) frame();
        btn = 4'd0;
        repeat (3) frame();
    endtask

    task automatic done(input logic ch);
        dp.move_done    = 1'b1;
        dp.move_changed = ch;
        tick();
        dp.move_done    = 1'b0;
        dp.move_changed = 1'b0;
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_welcome"}, show_welcome, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, dp.move_valid, 0);
        chk({tag, "_dir"}, dp.move_dir, 0);
        chk({tag, "_spawn"}, dp.spawn_req, 0);
        chk({tag, "_commit"}, grid_commit, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dt;
        dp.move_ready   = 1'b0;
        dp.move_done    = 1'b0;
        dp.move_changed = 1'b0;
        dp.spawn_done   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outs("rst");

        // welcome exit: press consumed, nothing queued
        btn = 4'b0001;
        frame();
        frame();
        chk("t1_still_welcome", show_welcome, 1);
        frame();
        chk("t1_welcome_off", show_welcome, 0);
        chk("t1_valid", dp.move_valid, 0);
        btn = 4'd0;
        repeat (3) frame();
        chk("t1_no_issue", issued.size(), 0);
        chk("t1_busy", busy, 0);

        // left move with change, spawn, commit on later frame
        dp.move_ready = 1'b1;
        ncommit = 0;
        press(4'b0100);
        chk("t2_n_issued", issued.size(), 1);
        chk("t2_dir", issued[0], 2);
        chk("t2_busy", busy, 1);
        repeat (5) tick();
        nspawn = 0;
        done(1'b1);
        chk("t2_spawn_on", dp.spawn_req, 1);
        repeat (9) tick();
        dp.spawn_done = 1'b1;
        frame_tick = 1'b1;
        tick();
        dp.spawn_done = 1'b0;
        frame_tick = 1'b0;
        chk("t2_spawn_cycles", nspawn, 10);
        chk("t2_spawn_off", dp.spawn_req, 0);
        chk("t2_no_commit_coincident", ncommit, 0);
        chk("t2_busy_wait", busy, 1);
        repeat (3) tick();
        chk("t2_no_commit_idle", ncommit, 0);
        frame();
        chk("t2_one_commit", ncommit, 1);
        chk("t2_idle", busy, 0);

        // simultaneous up+right resolves to up
        issued.delete();
        press(4'b1001);
        chk("t3_n_issued", issued.size(), 1);
        chk("t3_dir", issued[0], 0);
        done(1'b0);
        tick();
        chk("t3_idle", busy, 0);

        // overflow with ready low, then FIFO order
        dp.move_ready = 1'b0;
        issued.delete();
        press(4'b0010);
        press(4'b0100);
        chk("t4_no_ovf_yet", overflow, 0);
        press(4'b1000);
        chk("t4_ovf", overflow, 1);
        chk("t4_valid", dp.move_valid, 1);
        chk("t4_head", dp.move_dir, 1);
        chk("t4_none_taken", issued.size(), 0);
        dp.move_ready = 1'b1;
        tick();
        chk("t4_first", issued[0], 1);
        chk("t4_valid_drop", dp.move_valid, 0);

        // no-change moves: no spawn, no commit, next issues
        ncommit = 0;
        nspawn = 0;
        done(1'b0);
        repeat (3) tick();
        chk("t5_n_issued", issued.size(), 2);
        chk("t5_second", issued[1], 2);
        frame();
        chk("t5_no_commit", ncommit, 0);
        done(1'b0);
        repeat (3) tick();
        chk("t5_third_dropped", issued.size(), 2);
        chk("t5_no_spawn", nspawn, 0);
        chk("t5_idle", busy, 0);
        chk("t5_valid", dp.move_valid, 0);

        // datapath timeout in WAIT_MOVE
        issued.delete();
        press(4'b0001);
        chk("t6_issued", issued.size(), 1);
        for (int i = 0; i < 5000 && !timeout_err; i++) tick();
        chk("t6_tmo", timeout_err, 1);
        dt = cyc - hs_cyc;
        chk("t6_tmo_delay", (dt >= 4096 && dt <= 4098), 1);
        chk("t6_idle", busy, 0);
        chk("t6_not_welcome", show_welcome, 0);
        chk("t6_valid", dp.move_valid, 0);

        // reset in the middle of a spawn
        press(4'b0010);
        done(1'b1);
        chk("t6_in_spawn", dp.spawn_req, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outs("rst2");
        issued.delete();
        press(4'b0001);
        chk("rst2_left_welcome", show_welcome, 0);
        chk("rst2_queue_empty", dp.move_valid, 0);
        chk("rst2_no_issue", issued.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
